// File: rtl/wb_pkg.sv
// Shared definitions for the register-file write-back stage.
//   NREGS/AW/DW : register count, address width, data width.
//   wb_req_t    : one write-back request (valid, destination, data).
//   dest_onehot : decodes a destination into a per-register one-hot when enabled.
package wb_pkg;

   localparam int unsigned NREGS = 8;
   localparam int unsigned AW    = 3;
   localparam int unsigned DW    = 32;

   typedef struct packed {
      logic          valid;
      logic [AW-1:0] dest;
      logic [DW-1:0] data;
   } wb_req_t;

   function automatic logic [NREGS-1:0] dest_onehot(input logic en, input logic [AW-1:0] dest);
      dest_onehot = '0;
      if (en) dest_onehot[dest] = 1'b1;
   endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Load-result FIFO between the load unit and the write-back arbiter.
//   clk, reset            : clock, synchronous active-high reset (empties the FIFO)
//   push, push_dest/data  : enqueue one load result (ignored when full)
//   pop                   : discard/consume the head entry (ignored when empty)
//   head_dest, head_data  : oldest entry, meaningful only while !empty
//   count, full, empty    : occupancy status, all from registered state
// QDEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module wb_load_fifo
   import wb_pkg::*;
#(
   parameter int unsigned QDEPTH = 4,
   localparam int unsigned CW    = $clog2(QDEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [AW-1:0] push_dest,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [AW-1:0] head_dest,
   output logic [DW-1:0] head_data,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   localparam int unsigned PW = $clog2(QDEPTH);

   typedef struct packed {
      logic [AW-1:0] dest;
      logic [DW-1:0] data;
   } entry_t;

   entry_t        mem_q [QDEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push, do_pop;

   assign full    = (count_q == CW'(QDEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      count_q <= count_q + 1'b1;
         else if (do_pop && !do_push) count_q <= count_q - 1'b1;
      end
   end

   // Storage needs no reset: entries are only visible through the pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= '{dest: push_dest, data: push_data};
   end

   assign head_dest = mem_q[rd_ptr_q].dest;
   assign head_data = mem_q[rd_ptr_q].data;
   assign count     = count_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter in front of the two-write-port register file.
//   clk, reset                 : clock, synchronous active-high reset
//   alu0_*, alu1_*             : per-bundle-slot results, no backpressure
//   ld_valid/dest/data, ld_ready : load results, always buffered in the FIFO
//   rf_regWrite1/2, rf_writeData_1/2 : port enables and data (registered)
//   rf_dec, rf_sel             : per-register write enable and port-2 select
//   wb_conflict                : slot 0 dropped because slot 1 hit the same register
//   ld_squash                  : FIFO head discarded because an ALU wrote its register
//   q_count                    : FIFO occupancy
module regfile_wb_arbiter
   import wb_pkg::*;
#(
   parameter int unsigned QDEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             alu0_valid,
   input  logic [AW-1:0]    alu0_dest,
   input  logic [DW-1:0]    alu0_data,
   input  logic             alu1_valid,
   input  logic [AW-1:0]    alu1_dest,
   input  logic [DW-1:0]    alu1_data,
   input  logic             ld_valid,
   input  logic [AW-1:0]    ld_dest,
   input  logic [DW-1:0]    ld_data,
   output logic             ld_ready,
   output logic             rf_regWrite1,
   output logic             rf_regWrite2,
   output logic [DW-1:0]    rf_writeData_1,
   output logic [DW-1:0]    rf_writeData_2,
   output logic [NREGS-1:0] rf_dec,
   output logic [NREGS-1:0] rf_sel,
   output logic             wb_conflict,
   output logic             ld_squash,
   output logic [AW:0]      q_count
);

   localparam int unsigned CW = $clog2(QDEPTH) + 1;

   wb_req_t       alu0, alu1, ld_in;
   logic [AW-1:0] head_dest;
   logic [DW-1:0] head_data;
   logic [CW-1:0] fifo_count;
   logic          fifo_full, fifo_empty;
   logic          push, pop;

   assign alu0  = '{valid: alu0_valid, dest: alu0_dest, data: alu0_data};
   assign alu1  = '{valid: alu1_valid, dest: alu1_dest, data: alu1_data};
   assign ld_in = '{valid: ld_valid, dest: ld_dest, data: ld_data};

   // Registered count only: a pop on this edge does not open a slot until the next cycle.
   assign ld_ready = ~reset & ~fifo_full;
   assign push     = ld_in.valid & ld_ready;

   wb_load_fifo #(
      .QDEPTH (QDEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_dest (ld_in.dest),
      .push_data (ld_in.data),
      .pop       (pop),
      .head_dest (head_dest),
      .head_data (head_data),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   logic          conflict, alu0_win, head_valid, squash, ld_issue;
   logic          wr1_d, wr2_d;
   logic [AW-1:0] dest1_d, dest2_d;
   logic [DW-1:0] data1_d, data2_d;

   always_comb begin
      head_valid = ~fifo_empty;
      conflict   = alu0.valid & alu1.valid & (alu0.dest == alu1.dest);
      alu0_win   = alu0.valid & ~conflict;
      // An ALU result to the same register is younger than any queued load.
      squash     = head_valid & ((alu0.valid & (head_dest == alu0.dest)) |
                                 (alu1.valid & (head_dest == alu1.dest)));
      ld_issue   = head_valid & ~squash & ~(alu0_win & alu1.valid);

      wr1_d   = 1'b0;
      dest1_d = '0;
      data1_d = '0;
      wr2_d   = 1'b0;
      dest2_d = '0;
      data2_d = '0;

      if (alu0_win) begin
         wr1_d   = 1'b1;
         dest1_d = alu0.dest;
         data1_d = alu0.data;
      end else if (ld_issue) begin
         wr1_d   = 1'b1;
         dest1_d = head_dest;
         data1_d = head_data;
      end

      if (alu1.valid) begin
         wr2_d   = 1'b1;
         dest2_d = alu1.dest;
         data2_d = alu1.data;
      end else if (ld_issue && alu0_win) begin
         wr2_d   = 1'b1;
         dest2_d = head_dest;
         data2_d = head_data;
      end
   end

   assign pop = squash | ld_issue;

   logic             wr1_q, wr2_q, conflict_q, squash_q;
   logic [DW-1:0]    data1_q, data2_q;
   logic [NREGS-1:0] dec_q, sel_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr1_q      <= 1'b0;
         wr2_q      <= 1'b0;
         data1_q    <= '0;
         data2_q    <= '0;
         dec_q      <= '0;
         sel_q      <= '0;
         conflict_q <= 1'b0;
         squash_q   <= 1'b0;
      end else begin
         wr1_q      <= wr1_d;
         wr2_q      <= wr2_d;
         data1_q    <= data1_d;
         data2_q    <= data2_d;
         dec_q      <= dest_onehot(wr1_d, dest1_d) | dest_onehot(wr2_d, dest2_d);
         sel_q      <= dest_onehot(wr2_d, dest2_d);
         conflict_q <= conflict;
         squash_q   <= squash;
      end
   end

   // Conflict resolution and squashing together keep the two ports on distinct registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(wr1_d && wr2_d && (dest1_d == dest2_d)));
      end
   end

   assign rf_regWrite1   = wr1_q;
   assign rf_regWrite2   = wr2_q;
   assign rf_writeData_1 = data1_q;
   assign rf_writeData_2 = data2_q;
   assign rf_dec         = dec_q;
   assign rf_sel         = sel_q;
   assign wb_conflict    = conflict_q;
   assign ld_squash      = squash_q;
   assign q_count        = (AW + 1)'(fifo_count);

endmodule
